// File: rtl/vid_pkg.sv
// Shared types and defaults for the video output sequencer.
package vid_pkg;

  localparam int          DEF_DATA_W    = 24;
  localparam int          DEF_H_ACTIVE  = 640;
  localparam int          DEF_V_ACTIVE  = 480;
  localparam logic [23:0] DEF_BLANK_RGB = 24'h000000;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_ARM      = 2'd2,
    ST_RUN      = 2'd3
  } vseq_state_t;

endpackage

// File: rtl/video_out_seq_if.sv
// AXI4-Stream pixel link from the pixel source (master) to the sequencer (slave).
// A beat transfers on a clk_pix edge where s_tvalid && s_tready; while s_tvalid=1 and s_tready=0 the
// source holds s_tdata/s_tuser/s_tlast stable, and s_tvalid never waits on s_tready.
interface video_out_seq_if
  import vid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tuser;
  logic              s_tlast;

  modport master (output s_tdata, output s_tvalid, output s_tuser, output s_tlast, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tuser, input s_tlast, output s_tready);
endinterface

// File: rtl/video_out_seq_sat_cnt.sv
// Saturating event counter; a clear coinciding with an event leaves the count at 1.
module sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_pix,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk_pix) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/video_out_seq.sv
// Stream-to-raster sequencer: locks the pixel stream to the sync generator origin and resyncs on errors.
// Optional VSEQ_ERR_CNT_EN adds saturating underflow/resync counters; otherwise those ports read 0.
module video_out_seq
  import vid_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                H_ACTIVE  = DEF_H_ACTIVE,
  parameter int                V_ACTIVE  = DEF_V_ACTIVE,
  parameter logic [DATA_W-1:0] BLANK_RGB = DATA_W'(DEF_BLANK_RGB),
  parameter int                CNT_W     = 16
) (
  input  logic              clk_pix,
  input  logic              reset,
  input  logic              ctrl_enable,
  input  logic              status_clr,
  video_out_seq_if.slave    s_axis,
  output logic              tg_en,
  input  logic [11:0]       tg_sx,
  input  logic [11:0]       tg_sy,
  input  logic              tg_hsync,
  input  logic              tg_vsync,
  input  logic              tg_de,
  output logic              vid_hsync,
  output logic              vid_vsync,
  output logic              vid_de,
  output logic [DATA_W-1:0] vid_rgb,
  output logic              locked,
  output logic              underflow,
  output logic              frame_err,
  output logic [CNT_W-1:0]  underflow_cnt,
  output logic [CNT_W-1:0]  resync_cnt,
  output vseq_state_t       state_dbg
);

  vseq_state_t       state, state_nx;
  logic [11:0]       px, py;
  logic              origin, sof_exp, eol_exp;
  logic              popped, underflow_ev, frame_ev, resync_ev;
  logic              tready_c;
  logic [DATA_W-1:0] rgb_nx;

  assign origin       = (tg_sx == '0) && (tg_sy == '0);
  assign sof_exp      = (px == '0) && (py == '0);
  assign eol_exp      = (px == 12'(H_ACTIVE - 1));
  assign popped       = (state == ST_RUN) && tg_de && s_axis.s_tvalid;
  assign underflow_ev = (state == ST_RUN) && tg_de && !s_axis.s_tvalid;
  assign frame_ev     = popped && ((s_axis.s_tuser != sof_exp) || (s_axis.s_tlast != eol_exp));
  assign resync_ev    = (state == ST_RUN) && (state_nx == ST_FLUSH);
  assign rgb_nx       = popped ? s_axis.s_tdata : BLANK_RGB;

  always_ff @(posedge clk_pix) begin
    if (!reset) state <= ST_DISABLED;
    else        state <= state_nx;
  end

  // The SOF beat is held back in FLUSH/ARM so RUN pops it on the first active pixel.
  always_comb begin
    state_nx = state;
    tg_en    = 1'b0;
    tready_c = 1'b0;
    case (state)
      ST_DISABLED: begin
        if (ctrl_enable) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        tg_en    = 1'b1;
        tready_c = !(s_axis.s_tvalid && s_axis.s_tuser);
        if (!ctrl_enable)                          state_nx = ST_DISABLED;
        else if (s_axis.s_tvalid && s_axis.s_tuser) state_nx = ST_ARM;
      end
      ST_ARM: begin
        tg_en = 1'b1;
        if (!ctrl_enable) state_nx = ST_DISABLED;
        else if (origin)  state_nx = ST_RUN;
      end
      ST_RUN: begin
        tg_en    = 1'b1;
        tready_c = tg_de;
        if (underflow_ev || frame_ev)  state_nx = ST_FLUSH;
        else if (!ctrl_enable && origin) state_nx = ST_DISABLED;
      end
      default: state_nx = ST_DISABLED;
    endcase
  end

  assign s_axis.s_tready = tready_c;
  assign locked          = (state == ST_RUN);
  assign state_dbg       = state;

  always_ff @(posedge clk_pix) begin
    if (!reset) begin
      px <= '0;
      py <= '0;
    end else if (state == ST_ARM) begin
      px <= '0;
      py <= '0;
    end else if ((state == ST_RUN) && tg_de) begin
      if (eol_exp) begin
        px <= '0;
        py <= (py == 12'(V_ACTIVE - 1)) ? '0 : py + 12'd1;
      end else begin
        px <= px + 12'd1;
      end
    end
  end

  // Sync/de pass straight through one register so they stay aligned with vid_rgb.
  always_ff @(posedge clk_pix) begin
    if (!reset) begin
      vid_hsync <= 1'b0;
      vid_vsync <= 1'b0;
      vid_de    <= 1'b0;
      vid_rgb   <= BLANK_RGB;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vid_hsync <= tg_hsync;
      vid_vsync <= tg_vsync;
      vid_de    <= tg_de;
      vid_rgb   <= rgb_nx;
      underflow <= underflow_ev || (underflow && !status_clr);
      frame_err <= frame_ev || (frame_err && !status_clr);
    end
  end

`ifdef VSEQ_ERR_CNT_EN
  sat_cnt #(.CNT_W(CNT_W)) u_underflow_cnt (
    .clk_pix (clk_pix),
    .reset   (reset),
    .inc     (underflow_ev),
    .clr     (status_clr),
    .cnt     (underflow_cnt)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_resync_cnt (
    .clk_pix (clk_pix),
    .reset   (reset),
    .inc     (resync_ev),
    .clr     (status_clr),
    .cnt     (resync_cnt)
  );
`else
  assign underflow_cnt = '0;
  assign resync_cnt    = '0;
`endif

endmodule

// File: tb/tb_video_out_seq.sv
// Bench for video_out_seq on a reduced 16x8 raster: random frames, injected underflow/framing faults, enable/disable.
module tb_video_out_seq;
  import vid_pkg::*;

  localparam int          H_ACT = 16;
  localparam int          V_ACT = 8;
  localparam int          H_TOT = 20;
  localparam int          V_TOT = 11;
  localparam int          N_FR  = 10;
  localparam int          CNT_W = 8;
  localparam logic [23:0] BLANK = 24'h102030;

  // ---------------- clock / reset ----------------
  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic reset, ctrl_enable, clr_main, clr_src, status_clr;
  assign status_clr = clr_main | clr_src;

  logic [11:0]      tg_sx, tg_sy;
  logic             tg_hsync, tg_vsync, tg_de, tg_en;
  logic             vid_hsync, vid_vsync, vid_de, locked, underflow, frame_err;
  logic [23:0]      vid_rgb;
  logic [CNT_W-1:0] underflow_cnt, resync_cnt;
  vseq_state_t      state_dbg;

  video_out_seq_if #(.DATA_W(24)) sif ();

  video_out_seq #(
    .DATA_W(24), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .BLANK_RGB(BLANK), .CNT_W(CNT_W)
  ) dut (
    .clk_pix(clk_pix), .reset(reset), .ctrl_enable(ctrl_enable), .status_clr(status_clr),
    .s_axis(sif.slave), .tg_en(tg_en), .tg_sx(tg_sx), .tg_sy(tg_sy),
    .tg_hsync(tg_hsync), .tg_vsync(tg_vsync), .tg_de(tg_de),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de), .vid_rgb(vid_rgb),
    .locked(locked), .underflow(underflow), .frame_err(frame_err),
    .underflow_cnt(underflow_cnt), .resync_cnt(resync_cnt), .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_cnts(input int exp_uf, input int exp_rs);
`ifdef VSEQ_ERR_CNT_EN
    check("underflow_cnt", 32'(underflow_cnt), 32'(exp_uf));
    check("resync_cnt", 32'(resync_cnt), 32'(exp_rs));
`else
    check("underflow_cnt_tied", 32'(underflow_cnt), 32'(0 * exp_uf));
    check("resync_cnt_tied", 32'(resync_cnt), 32'(0 * exp_rs));
`endif
  endtask

  // ---------------- stimulus data ----------------
  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        garbage;
    int          hole;   // 1: drop valid one cycle, 2: same plus status_clr
  } beat_t;

  beat_t       src_q[$];
  logic [23:0] pix [N_FR][V_ACT][H_ACT];
  int          garb_pops = 0;

  // Raster frame r (1..9) shows source frame r-1; fault rasters stop the picture at the faulty pixel.
  function automatic logic [23:0] exp_rgb(input int r, input int x, input int y, input logic de);
    int flin, lin;
    bit fshow;
    flin  = -1;
    fshow = 1'b0;
    if (!de || r < 1 || r > 9) return BLANK;
    case (r)
      4: flin = 3 * H_ACT + 10;
      6: begin flin = 2 * H_ACT + 14; fshow = 1'b1; end
      8: flin = 1 * H_ACT + 5;
      default: flin = -1;
    endcase
    lin = y * H_ACT + x;
    if (flin < 0 || lin < flin) return pix[r-1][y][x];
    if (lin == flin && fshow) return pix[r-1][y][x];
    return BLANK;
  endfunction

  // ---------------- sync generator model ----------------
  int sx = 0, sy = 0, raster = 0;
  int de_x = 0, de_y = 0, de_r = 0;
  int v_x = 0, v_y = 0, v_r = 0;
  logic v_de = 1'b0, v_hs = 1'b0, v_vs = 1'b0;

  initial begin
    tg_sx = '0; tg_sy = '0; tg_de = 1'b0; tg_hsync = 1'b0; tg_vsync = 1'b0;
    forever begin
      @(posedge clk_pix);
      #1;
      v_de = tg_de; v_hs = tg_hsync; v_vs = tg_vsync;
      v_x = de_x; v_y = de_y; v_r = de_r;
      tg_de    = (sx < H_ACT) && (sy < V_ACT);
      tg_hsync = (sx >= 17) && (sx <= 18);
      tg_vsync = (sy == 9);
      de_x = sx; de_y = sy; de_r = raster;
      if (sx == H_TOT - 1) begin
        sx = 0;
        if (sy == V_TOT - 1) begin sy = 0; raster++; end
        else sy++;
      end else begin
        sx++;
      end
      tg_sx = 12'(sx);
      tg_sy = 12'(sy);
    end
  end

  // ---------------- stream source driver ----------------
  initial begin
    logic fire;
    sif.s_tvalid = 1'b0; sif.s_tdata = '0; sif.s_tuser = 1'b0; sif.s_tlast = 1'b0;
    clr_src = 1'b0;
    forever begin
      @(negedge clk_pix);
      fire = sif.s_tvalid && sif.s_tready;
      @(posedge clk_pix);
      #1;
      if (fire === 1'b1 && src_q.size() > 0) begin
        if (src_q[0].garbage) garb_pops++;
        void'(src_q.pop_front());
      end
      clr_src = 1'b0;
      if (src_q.size() == 0) begin
        sif.s_tvalid = 1'b0;
      end else if (src_q[0].hole != 0) begin
        sif.s_tvalid = 1'b0;
        clr_src      = (src_q[0].hole == 2);
        src_q[0].hole = 0;
      end else begin
        sif.s_tvalid = 1'b1;
        sif.s_tdata  = src_q[0].data;
        sif.s_tuser  = src_q[0].user;
        sif.s_tlast  = src_q[0].last;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic mon_on = 1'b0;
  logic en_window = 1'b0;
  int   tg_en_drops = 0;

  initial begin
    wait (mon_on);
    forever begin
      @(negedge clk_pix);
      check("vid_sync", 32'({vid_hsync, vid_vsync, vid_de}), 32'({v_hs, v_vs, v_de}));
      check($sformatf("vid_rgb r%0d x%0d y%0d de%0d", v_r, v_x, v_y, v_de),
            32'(vid_rgb), 32'(exp_rgb(v_r, v_x, v_y, v_de)));
      if (en_window && raster <= 9 && !tg_en) tg_en_drops++;
    end
  end

  task automatic wait_pos(input int r, input int x, input int y);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk_pix);
      if (raster == r && sx == x && sy == y) found = 1'b1;
    end
    check($sformatf("wait r%0d x%0d y%0d", r, x, y), 32'(found), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    beat_t b;
    reset = 1'b0; ctrl_enable = 1'b0; clr_main = 1'b0;

    for (int g = 0; g < 5; g++) begin
      b.data = 24'($urandom); b.user = 1'b0; b.last = 1'($urandom_range(0, 1));
      b.garbage = 1'b1; b.hole = 0;
      src_q.push_back(b);
    end
    for (int f = 0; f < N_FR; f++)
      for (int y = 0; y < V_ACT; y++)
        for (int x = 0; x < H_ACT; x++) begin
          pix[f][y][x] = 24'($urandom);
          if (!(f == 5 && y == 2 && x == 15)) begin
            b.data    = pix[f][y][x];
            b.user    = (x == 0 && y == 0);
            b.last    = (x == H_ACT - 1) || (f == 5 && y == 2 && x == 14);
            b.garbage = 1'b0;
            b.hole    = (f == 3 && x == 10 && y == 3) ? 1 : (f == 7 && x == 5 && y == 1) ? 2 : 0;
            src_q.push_back(b);
          end
        end

    repeat (3) @(negedge clk_pix);
    check("rst_state", 32'(state_dbg), 32'(ST_DISABLED));
    check("rst_tg_en", 32'(tg_en), 32'd0);
    check("rst_tready", 32'(sif.s_tready), 32'd0);
    check("rst_vid", 32'({vid_hsync, vid_vsync, vid_de}), 32'd0);
    check("rst_rgb", 32'(vid_rgb), 32'(BLANK));
    check("rst_flags", 32'({locked, underflow, frame_err}), 32'd0);
    check_cnts(0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk_pix);
    mon_on = 1'b1;

    // Lock: garbage flushed, SOF held in ARM, RUN from the next origin.
    wait_pos(0, 0, 5);
    ctrl_enable = 1'b1;
    @(negedge clk_pix);
    check("en_flush", 32'(state_dbg), 32'(ST_FLUSH));
    check("en_tg_en", 32'(tg_en), 32'd1);
    en_window = 1'b1;
    wait_pos(0, 0, 9);
    check("arm_state", 32'(state_dbg), 32'(ST_ARM));
    check("arm_tready", 32'(sif.s_tready), 32'd0);
    check("garbage_pops", 32'(garb_pops), 32'd5);
    wait_pos(1, 2, 0);
    check("run_state", 32'(state_dbg), 32'(ST_RUN));
    check("run_locked", 32'(locked), 32'd1);
    wait_pos(4, 0, 0);
    check("ideal_flags", 32'({underflow, frame_err}), 32'd0);
    check_cnts(0, 0);

    // Underflow at pixel (10,3) of raster 4.
    wait_pos(4, 0, 4);
    check("uf_flag", 32'(underflow), 32'd1);
    check("uf_state", 32'(state_dbg), 32'(ST_FLUSH));
    check("uf_ferr", 32'(frame_err), 32'd0);
    check_cnts(1, 1);
    wait_pos(5, 2, 0);
    check("relock_state", 32'(state_dbg), 32'(ST_RUN));

    // Short line (early tlast) in raster 6.
    wait_pos(6, 0, 3);
    check("ferr_flag", 32'(frame_err), 32'd1);
    check("ferr_state", 32'(state_dbg), 32'(ST_FLUSH));
    check("ferr_tg_en", 32'(tg_en), 32'd1);
    check_cnts(1, 2);

    wait_pos(7, 0, 5);
    clr_main = 1'b1;
    @(negedge clk_pix);
    clr_main = 1'b0;
    check("clr_flags", 32'({underflow, frame_err}), 32'd0);
    check("clr_state", 32'(state_dbg), 32'(ST_RUN));
    check_cnts(0, 0);

    // Underflow coinciding with status_clr in raster 8.
    wait_pos(8, 0, 3);
    check("clr_race_flag", 32'(underflow), 32'd1);
    check("clr_race_state", 32'(state_dbg), 32'(ST_FLUSH));
    check_cnts(1, 1);

    // Disable mid-frame: finish raster 9, stop at the origin.
    wait_pos(9, 0, 4);
    check("dis_req_state", 32'(state_dbg), 32'(ST_RUN));
    ctrl_enable = 1'b0;
    wait_pos(9, 0, V_ACT - 1);
    check("dis_finish_state", 32'(state_dbg), 32'(ST_RUN));
    check("dis_finish_tg_en", 32'(tg_en), 32'd1);
    wait_pos(10, 2, 0);
    check("dis_state", 32'(state_dbg), 32'(ST_DISABLED));
    check("dis_tg_en", 32'(tg_en), 32'd0);
    check("dis_locked", 32'(locked), 32'd0);
    check("dis_tready", 32'(sif.s_tready), 32'd0);
    wait_pos(10, 0, 9);
    check("tg_en_drops", 32'(tg_en_drops), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_out_seq.md
# video_out_seq

Sequencer between the AXI4-Stream pixel source and the HDMI sync generator. It enables the timing generator and discards stream data until a start-of-frame beat arrives. It then starts the frame at the timing origin and pops exactly one stream beat per active pixel. It checks the SOF/EOL framing against the active raster and resynchronises on any mismatch or underflow. Outputs are registered sync/de/rgb, aligned to each other, which feed the TMDS encoders.

## Interface
- DATA_W, 24, pixel width (8:8:8 RGB)
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BLANK_RGB, 24'h000000, colour driven when no beat is popped
- CNT_W, 16, error counter width (only with VSEQ_ERR_CNT_EN)

Ports:
- clk_pix  in  1  pixel clock
- reset  in  1  synchronous, active-low
- ctrl_enable  in  1  run request
- status_clr  in  1  clears sticky flags and counters
- s_tdata  in  DATA_W  stream pixel
- s_tvalid  in  1  stream valid
- s_tready  out  1  stream ready
- s_tuser  in  1  start of frame (first pixel)
- s_tlast  in  1  end of line (last pixel of line)
- tg_en  out  1  drives sync generator rgb_valid
- tg_sx, tg_sy  in  12  sync generator counters
- tg_hsync, tg_vsync, tg_de  in  1  sync generator registered outputs
- vid_hsync, vid_vsync, vid_de  out  1  tg_* delayed by one register
- vid_rgb  out  DATA_W  pixel aligned to vid_de
- locked  out  1  high in RUN
- underflow  out  1  sticky: tg_de high in RUN with s_tvalid low
- frame_err  out  1  sticky: SOF/EOL mismatch
- underflow_cnt, resync_cnt  out  CNT_W  saturating counters (macro only)

## Operation
- States: DISABLED, FLUSH, ARM, RUN.
- DISABLED:
  - tg_en=0, s_tready=0.
  - ctrl_enable=1 moves to FLUSH.
- FLUSH:
  - tg_en=1, s_tready = !(s_tvalid & s_tuser). Non-SOF beats are discarded.
  - s_tvalid & s_tuser moves to ARM. The SOF beat is not consumed.
- ARM:
  - tg_en=1, s_tready=0.
  - tg_sx==0 && tg_sy==0 moves to RUN. Position counters px and py are cleared to 0.
- RUN:
  - s_tready = tg_de.
  - Every cycle with tg_de=1 advances px. At px==H_ACTIVE-1, px wraps to 0 and py increments; py wraps at V_ACTIVE-1.
  - Popped beat: vid_rgb = s_tdata.
  - tg_de=1 with s_tvalid=0: vid_rgb = BLANK_RGB, set underflow, move to FLUSH.
  - Popped beat where s_tuser != (px==0 && py==0), or s_tlast != (px==H_ACTIVE-1): set frame_err, move to FLUSH. The offending beat is consumed and displayed.
- ctrl_enable low:
  - In FLUSH or ARM: move to DISABLED immediately.
  - In RUN: move to DISABLED at the next tg_sx==0 && tg_sy==0, so no partial frame is shown.
- Outside RUN, and in RUN with tg_de=0, vid_rgb = BLANK_RGB.
- tg_en never drops while in FLUSH, ARM or RUN. The display raster stays continuous through a resync.
- status_clr clears the flags. A same-cycle new event wins, leaving the flag set and the counter at 1.
- Every FLUSH entry from RUN counts as one resync.

## Timing
- Reset values:
  - State DISABLED.
  - All outputs 0, except vid_rgb = BLANK_RGB.
  - px, py, flags and counters 0.
- s_tready and tg_en are combinational from state and inputs. All vid_* outputs are registered.
- Latency: a beat popped at cycle t appears on vid_rgb at t+1, together with vid_de = tg_de(t).
- Handshake: a beat transfers when s_tvalid && s_tready. The source must hold s_tdata while s_tvalid=1 and s_tready=0.
- Reset mid-frame returns to DISABLED on the next edge. Sync generator counters are not touched.

## Configuration
- VSEQ_ERR_CNT_EN defined:
  - underflow_cnt counts underflow events.
  - resync_cnt counts RUN to FLUSH transitions.
  - Both saturate at all-ones and clear on status_clr.
- Undefined: both counter ports tie to 0, no counter registers are built, and the sticky flags are unchanged.

## Structure
- Shared package vid_pkg:
  - State enum vseq_state_t.
  - Default H_ACTIVE and V_ACTIVE constants.
  - BLANK_RGB default, DATA_W.
- Sub-module sat_cnt (CNT_W parameter; inc, clr inputs), instantiated twice under the macro.

## Test plan
- Stream of 640x480 frames, ideal source, ctrl_enable=1 after reset:
  - FLUSH, then ARM, then RUN at the first origin.
  - vid_rgb matches pixel (x,y) at every vid_de for 3 frames.
  - underflow=0, frame_err=0.
- 5 garbage beats before SOF: all 5 discarded in FLUSH, and the first displayed pixel is the SOF beat.
- s_tvalid dropped for 1 cycle at active pixel (10,3):
  - BLANK_RGB output on that pixel, underflow=1, state FLUSH.
  - Relock on the next frame. resync_cnt=1 with the macro defined.
- Line of 639 beats (early s_tlast):
  - frame_err=1 and resync.
  - tg_en stays 1 throughout, so hsync/vsync are uninterrupted.
- ctrl_enable deasserted mid-frame at line 200: the frame completes, then DISABLED at the origin with tg_en=0.
- status_clr asserted in the same cycle as an underflow: underflow stays 1, and underflow_cnt reads 1.
